// File: rtl/irq_ctrl.sv
// Interrupt controller: latches edge/level sources, masks them, picks the
// lowest-index active source and runs a claim/complete handshake with the core.
module irq_ctrl #(
  parameter int              NSRC   = 8,
  parameter logic [NSRC-1:0] RST_EN = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] src_in,
  input  logic            sel,
  input  logic            we,
  input  logic [2:0]      addr,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  output logic            ready,
  output logic            irq_out
);

  typedef enum logic [1:0] {IDLE, PEND, SERVICE} state_t;

  state_t          state, state_nxt;
  logic [NSRC-1:0] pending, enable, edge_en, src_q;
  logic [4:0]      claim_id;

  logic [NSRC-1:0] act, first_act, rise, w1c, claim_clr, pending_nxt;
  logic [4:0]      best_id;
  logic            wr, rd, claim_rd, complete_ok;
  logic [31:0]     rd_val;

  assign wr  = sel & we;
  assign rd  = sel & ~we;
  assign act = pending & enable;
  // Two's-complement trick isolates the lowest set bit of act.
  assign first_act = act & (~act + NSRC'(1));

  assign claim_rd    = rd && (addr == 3'd3) && (state == PEND) && (act != '0);
  assign complete_ok = wr && (addr == 3'd4) && (state == SERVICE) && (wdata[4:0] == claim_id);

  always_comb begin
    best_id = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (act[i]) best_id = 5'(i + 1);
    end
  end

  // Edge bits: sticky, cleared by W1C or claim, but a same-cycle rise wins.
  assign rise        = src_in & ~src_q & edge_en;
  assign w1c         = (wr && addr == 3'd0) ? wdata[NSRC-1:0] : '0;
  assign claim_clr   = claim_rd ? first_act : '0;
  assign pending_nxt = (edge_en & ((pending & ~w1c & ~claim_clr) | rise)) |
                       (~edge_en & src_in);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (act != '0) state_nxt = PEND;
      PEND: begin
        if (claim_rd)        state_nxt = SERVICE;
        else if (act == '0)  state_nxt = IDLE;
      end
      SERVICE: if (complete_ok) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_val = '0;
    case (addr)
      3'd0:    rd_val = 32'(pending);
      3'd1:    rd_val = 32'(enable);
      3'd2:    rd_val = 32'(edge_en);
      3'd3:    rd_val = claim_rd ? 32'(best_id) : '0;
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      irq_out  <= 1'b0;
      ready    <= 1'b0;
      rdata    <= '0;
      src_q    <= '0;
      pending  <= '0;
      enable   <= RST_EN;
      edge_en  <= '0;
      claim_id <= '0;
    end else begin
      state   <= state_nxt;
      irq_out <= (state_nxt == PEND);
      ready   <= sel;
      src_q   <= src_in;
      pending <= pending_nxt;
      if (rd)                  rdata    <= rd_val;
      if (wr && addr == 3'd1)  enable   <= wdata[NSRC-1:0];
      if (wr && addr == 3'd2)  edge_en  <= wdata[NSRC-1:0];
      if (claim_rd)            claim_id <= best_id;
    end
  end

endmodule
